vga_plot_arbiter: RTL and testbench

- Shares the single VGA adapter pixel-write port between N sprite controllers (player, enemy, bullet draw/erase FSMs).
- Each controller raises a request, receives an exclusive grant for a whole draw or erase pass, and signals done; grants are issued round-robin.
- Sits between the sprite control/datapath pairs and the VGA adapter.
- A watchdog forcibly reclaims the port from a requester that holds it too long.

---
 rtl/vga_plot_arbiter.sv | 177 +++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin arbiter sharing one VGA pixel-write port
//
// Grants the VGA adapter write port to one sprite controller at a time for a
// whole draw/erase pass, forwards the owner's pixel stream through one register
// stage, and reclaims the port through a watchdog if a pass runs too long.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   req/done/plot_in       per-requester request level, end-of-pass strobe, write enable
//   x_in/y_in/colour_in    packed per-requester pixel data, requester i at [i*W +: W]
//   grant                  one-hot owner, zero when the port is free
//   vga_x/vga_y/vga_colour registered pixel to the VGA adapter
//   vga_plot               registered write enable to the VGA adapter
//   busy                   high while a grant is held
//   timeout                sticky, set when the watchdog forces a release
module vga_plot_arbiter #(
    parameter int N_REQ    = 4,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int MAX_HOLD = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          done,
    input  logic [N_REQ-1:0]          plot_in,
    input  logic [N_REQ*X_W-1:0]      x_in,
    input  logic [N_REQ*Y_W-1:0]      y_in,
    input  logic [N_REQ*COLOUR_W-1:0] colour_in,
    output logic [N_REQ-1:0]          grant,
    output logic [X_W-1:0]            vga_x,
    output logic [Y_W-1:0]            vga_y,
    output logic [COLOUR_W-1:0]       vga_colour,
    output logic                      vga_plot,
    output logic                      busy,
    output logic                      timeout
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [X_W-1:0]        vx_q, vx_d;
    logic [Y_W-1:0]        vy_q, vy_d;
    logic [COLOUR_W-1:0]   vc_q, vc_d;
    logic                  vplot_q, vplot_d;
    logic                  timeout_q, timeout_d;

    logic [X_W-1:0]        x_arr [N_REQ];
    logic [Y_W-1:0]        y_arr [N_REQ];
    logic [COLOUR_W-1:0]   c_arr [N_REQ];

    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      cand;
    logic                  hold_expired;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign x_arr[gi] = x_in[gi*X_W +: X_W];
        assign y_arr[gi] = y_in[gi*Y_W +: Y_W];
        assign c_arr[gi] = colour_in[gi*COLOUR_W +: COLOUR_W];
    end

    // Scan from the highest offset down so the last hit written is the one
    // closest to the pointer, giving round-robin priority starting at ptr_q.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr_q) + i) % N_REQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign hold_expired = (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        vc_d      = vc_q;
        vplot_d   = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_valid) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    grant_d = N_REQ'(1) << pick_idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                // The owner's pixel is forwarded even on its exit cycle so a
                // final pixel accompanying done is not lost.
                vx_d    = x_arr[owner_q];
                vy_d    = y_arr[owner_q];
                vc_d    = c_arr[owner_q];
                vplot_d = plot_in[owner_q];
                hold_d  = hold_q + HOLD_W'(1);
                if (done[owner_q] || !req[owner_q] || hold_expired) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    if (hold_expired) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            RELEASE: begin
                grant_d = '0;
                ptr_d   = IDX_W'((int'(owner_q) + 1) % N_REQ);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            vc_q      <= '0;
            vplot_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            vc_q      <= vc_d;
            vplot_q   <= vplot_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant      = grant_q;
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vc_q;
    assign vga_plot   = vplot_q;
    assign busy       = (state_q == GRANT);
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - scoreboard bench for vga_plot_arbiter
module tb_vga_plot_arbiter;

    localparam int N   = 4;
    localparam int XW  = 8;
    localparam int YW  = 7;
    localparam int CW  = 3;
    localparam int MH  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, done, plot_in;
    logic [N*XW-1:0] x_in;
    logic [N*YW-1:0] y_in;
    logic [N*CW-1:0] colour_in;
    logic [N-1:0]    grant;
    logic [XW-1:0]   vga_x;
    logic [YW-1:0]   vga_y;
    logic [CW-1:0]   vga_colour;
    logic            vga_plot, busy, timeout;

    int n_vec = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;
    logic [N-1:0] prev_grant = '0;

    logic [31:0] pix_q [$];
    logic [N-1:0] gnt_q [$];

    vga_plot_arbiter #(
        .N_REQ(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .MAX_HOLD(MH)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .plot_in(plot_in),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int idx, input logic [XW-1:0] x,
                           input logic [YW-1:0] y, input logic [CW-1:0] c);
        x_in[idx*XW +: XW]      = x;
        y_in[idx*YW +: YW]      = y;
        colour_in[idx*CW +: CW] = c;
    endtask

    function automatic logic [31:0] pix_word(input logic [XW-1:0] x,
                                             input logic [YW-1:0] y, input logic [CW-1:0] c);
        return 32'({x, y, c});
    endfunction

    task automatic wait_grant(input string tag);
        for (int k = 0; k < 20 && grant == '0; k++) tick();
        if (grant == '0) check({tag, "_wait_tmo"}, 32'(grant), 32'hFFFF_FFFF);
    endtask

    // Pixel and grant scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("onehot", 32'($onehot0(grant)), 32'd1);
            if (vga_plot) begin
                if (pix_q.size() == 0) check("pix_unexpected", pix_word(vga_x, vga_y, vga_colour), 32'hFFFF_FFFF);
                else check("pix", pix_word(vga_x, vga_y, vga_colour), pix_q.pop_front());
            end
            if (grant != '0 && prev_grant == '0) begin
                if (gnt_q.size() == 0) check("gnt_unexpected", 32'(grant), 32'hFFFF_FFFF);
                else check("gnt_order", 32'(grant), 32'(gnt_q.pop_front()));
            end
            prev_grant = grant;
        end
    end

    initial begin
        logic [N-1:0] served;
        int cnt;
        reset = 1'b1; req = '0; done = '0; plot_in = '0;
        x_in = '0; y_in = '0; colour_in = '0;
        tick(); tick();
        check("rst_grant", 32'(grant), 0);
        check("rst_plot", 32'(vga_plot), 0);
        check("rst_x", 32'(vga_x), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout", 32'(timeout), 0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick(); tick();

        // Single requester
        req = 4'b0010; gnt_q.push_back(4'b0010);
        tick();
        check("single_grant", 32'(grant), 32'h2);
        check("single_busy", 32'(busy), 1);
        plot_in = 4'b0010; set_pix(1, 8'h20, 7'h10, 3'd5);
        pix_q.push_back(pix_word(8'h20, 7'h10, 3'd5));
        tick();
        check("single_plot", 32'(vga_plot), 1);
        check("single_x", 32'(vga_x), 32'h20);
        check("single_y", 32'(vga_y), 32'h10);
        plot_in = '0; done = 4'b0010;
        tick();
        check("single_rel_grant", 32'(grant), 0);
        check("single_rel_busy", 32'(busy), 0);
        check("single_rel_plot", 32'(vga_plot), 0);
        done = '0; req = '0;
        tick(); tick();

        // Non-owner isolation: requester 2 drives plot/done with x=0xFF
        req = 4'b0001; gnt_q.push_back(4'b0001);
        wait_grant("iso");
        check("iso_grant", 32'(grant), 32'h1);
        set_pix(2, 8'hFF, 7'h7F, 3'd7);
        for (int i = 0; i < 4; i++) begin
            plot_in = {1'b0, 1'b1, 1'b0, 1'(i % 2 == 0)};
            done = 4'b0100;
            set_pix(0, 8'(i + 1), 7'(i + 3), 3'(i));
            if (i % 2 == 0) pix_q.push_back(pix_word(8'(i + 1), 7'(i + 3), 3'(i)));
            tick();
            check("iso_x_not_ff", 32'(vga_x != 8'hFF), 1);
            check("iso_plot", 32'(vga_plot), 32'(i % 2 == 0));
            check("iso_hold_grant", 32'(grant), 32'h1);
        end
        plot_in = 4'b0001; done = 4'b0001; set_pix(0, 8'h42, 7'h21, 3'd2);
        pix_q.push_back(pix_word(8'h42, 7'h21, 3'd2));
        tick();
        check("iso_final_pixel", 32'(vga_plot), 1);
        check("iso_rel", 32'(grant), 0);
        plot_in = '0; done = '0; req = '0;
        tick(); tick();

        // Round-robin fairness from pointer 0
        reset = 1'b1; tick(); reset = 1'b0;
        prev_grant = '0;
        req = 4'b1111;
        gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010);
        gnt_q.push_back(4'b0100); gnt_q.push_back(4'b1000);
        gnt_q.push_back(4'b0001);
        served = '0;
        for (int g = 0; g < 5; g++) begin
            wait_grant("rr");
            if (g < 4) check("rr_norepeat", 32'(served & grant), 0);
            served = served | grant;
            tick(); tick();
            done = grant;
            if (g == 4) req = '0;
            tick();
            done = '0;
        end
        check("rr_all_served", 32'(served), 32'hF);
        tick(); tick();

        // Request withdrawal
        req = 4'b0100; gnt_q.push_back(4'b0100);
        wait_grant("wd");
        tick(); tick();
        req = '0;
        tick();
        check("wd_rel_grant", 32'(grant), 0);
        check("wd_rel_busy", 32'(busy), 0);
        check("wd_timeout", 32'(timeout), 0);
        req = 4'b1001; gnt_q.push_back(4'b1000); gnt_q.push_back(4'b0001);
        wait_grant("wd_next");
        check("wd_ptr_adv", 32'(grant), 32'h8);
        done = 4'b1000; req = 4'b0001;
        tick();
        done = '0;
        wait_grant("wd_next2");
        check("wd_next2", 32'(grant), 32'h1);
        req = '0;
        tick(); tick(); tick();

        // Watchdog
        req = 4'b1000; gnt_q.push_back(4'b1000); gnt_q.push_back(4'b0001);
        wait_grant("wdog");
        req = 4'b1001;
        cnt = 0;
        for (int k = 0; k < 20 && grant == 4'b1000; k++) begin
            tick();
            cnt++;
        end
        check("wdog_hold_cycles", 32'(cnt), MH);
        check("wdog_timeout", 32'(timeout), 1);
        wait_grant("wdog_next");
        check("wdog_next", 32'(grant), 32'h1);
        done = 4'b0001; req = '0;
        tick();
        done = '0;
        tick(); tick();
        check("wdog_sticky", 32'(timeout), 1);

        // Reset mid-grant
        req = 4'b0001; gnt_q.push_back(4'b0001);
        wait_grant("rst");
        tick();
        plot_in = 4'b0001; set_pix(0, 8'h55, 7'h2A, 3'd3);
        reset = 1'b1;
        tick();
        check("rstm_grant", 32'(grant), 0);
        check("rstm_plot", 32'(vga_plot), 0);
        check("rstm_timeout", 32'(timeout), 0);
        reset = 1'b0; plot_in = '0;
        gnt_q.push_back(4'b0001);
        tick();
        check("rstm_regrant", 32'(grant), 32'h1);
        done = 4'b0001; req = '0;
        tick();
        done = '0;
        tick(); tick();

        check("pixq_empty", 32'(pix_q.size()), 0);
        check("gntq_empty", 32'(gnt_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
